row_spare_alloc: RTL and testbench

- Sequential row-spare allocation register file for the BIRA datapath.
- Accepts a stream of faulty-row addresses. Each one is the new pivot row NPr = {block[1:0], addr[9:0]}.
- Holds the four row-repair registers RRx1..RRx4 and their valid flags RLSS, and drives them to the NP comparator stage.
- Uses the comparator's combinational comp result to choose per fault: already covered (hit), allocate a new spare, or declare the memory unrepairable.

---
 rtl/bira_pkg.sv | 37 +++
 rtl/row_spare_alloc_if.sv | 22 ++
 rtl/spare_lane.sv | 41 ++++
 rtl/row_spare_alloc.sv | 141 ++++++++++++++
 tb/tb_row_spare_alloc.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bira_pkg.sv
// Shared types, sizes and helpers for the BIRA row-spare allocation datapath.
package bira_pkg;

    localparam int ADDR_W    = 10;
    localparam int BLK_W     = 2;
    localparam int ROW_W     = BLK_W + ADDR_W;
    localparam int NUM_SPARE = 4;
    localparam int HIT_W     = 4;
    localparam int CNT_W     = 3;
    localparam int IDX_W     = 2;

    // Spare count at which the next allocation uses the final spare.
    localparam logic [CNT_W-1:0] LAST_FREE_CNT = CNT_W'(NUM_SPARE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        FULL    = 3'd2,
        DONE    = 3'd3,
        FAIL    = 3'd4
    } state_t;

    // Index of the lowest lane whose valid bit is clear; lane 0 when none are free.
    function automatic logic [IDX_W-1:0] lowest_free(input logic [NUM_SPARE-1:0] rlss);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_SPARE - 1; i >= 0; i--) begin
            if (!rlss[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_spare_alloc_if.sv
// Fault stream plus comparator handshake between the fault source and the allocator.
interface row_spare_alloc_if;
    import bira_pkg::*;

    logic             fault_valid;
    logic             fault_ready;
    logic [ROW_W-1:0] fault_row;
    logic             fault_last;
    logic             comp;
    logic [ROW_W-1:0] NPr;

    modport master (
        output fault_valid, fault_row, fault_last, comp,
        input  fault_ready, NPr
    );

    modport slave (
        input  fault_valid, fault_row, fault_last, comp,
        output fault_ready, NPr
    );

endinterface

// File: rtl/spare_lane.sv
// One row-repair lane: stored row address, its valid flag and a saturating hit counter.
module spare_lane
    import bira_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [ROW_W-1:0] row_i,
    output logic [ROW_W-1:0] row_o,
    output logic             vld_o,
    output logic [HIT_W-1:0] hits_o
);

    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    logic [ROW_W-1:0] row_q;
    logic             vld_q;
    logic [HIT_W-1:0] hits_q;

    // Lane storage: clear on reset/start, load on allocation, count hits up to saturation.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            row_q  <= {ROW_W{1'b0}};
            vld_q  <= 1'b0;
            hits_q <= {HIT_W{1'b0}};
        end else if (load_i) begin
            row_q  <= row_i;
            vld_q  <= 1'b1;
            hits_q <= {{(HIT_W-1){1'b0}}, 1'b1};
        end else if (inc_i && (hits_q != HIT_MAX)) begin
            hits_q <= hits_q + {{(HIT_W-1){1'b0}}, 1'b1};
        end
    end

    assign row_o  = row_q;
    assign vld_o  = vld_q;
    assign hits_o = hits_q;

endmodule

// File: rtl/row_spare_alloc.sv
// Row-spare allocator: tracks four repair rows, counts hits and decides repairability.
module row_spare_alloc
    import bira_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    row_spare_alloc_if.slave           fif,
    output logic [ROW_W-1:0]           RRx1,
    output logic [ROW_W-1:0]           RRx2,
    output logic [ROW_W-1:0]           RRx3,
    output logic [ROW_W-1:0]           RRx4,
    output logic [NUM_SPARE-1:0]       RLSS,
    output logic [CNT_W-1:0]           spare_cnt,
    output logic [NUM_SPARE*HIT_W-1:0] hit_cnt,
    output logic                       done,
    output logic                       unrepairable
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     spare_cnt_q, spare_cnt_d;
    logic                 done_q, unrep_q;

    logic [ROW_W-1:0]     lane_row_s  [NUM_SPARE];
    logic [HIT_W-1:0]     lane_hits_s [NUM_SPARE];
    logic [NUM_SPARE-1:0] lane_vld_s;
    logic [NUM_SPARE-1:0] lane_load_s;
    logic [NUM_SPARE-1:0] lane_inc_s;

    logic                 ready_s, accept_s, hit_s, miss_s, alloc_s;
    logic [IDX_W-1:0]     free_idx_s;

    assign ready_s         = (state_q == COLLECT) || (state_q == FULL);
    assign fif.fault_ready = ready_s;
    assign fif.NPr         = fif.fault_row;

    // Accept qualification and per-lane load/increment strobes; start blocks any accept.
    always_comb begin
        accept_s    = fif.fault_valid & ready_s & ~start;
        hit_s       = accept_s & fif.comp;
        miss_s      = accept_s & ~fif.comp;
        alloc_s     = miss_s & (state_q == COLLECT);
        free_idx_s  = lowest_free(lane_vld_s);
        lane_load_s = {NUM_SPARE{1'b0}};
        lane_inc_s  = {NUM_SPARE{1'b0}};
        for (int i = 0; i < NUM_SPARE; i++) begin
            lane_load_s[i] = alloc_s & (free_idx_s == IDX_W'(i));
            lane_inc_s[i]  = hit_s & lane_vld_s[i] & (lane_row_s[i] == fif.fault_row);
        end
    end

    // Next-state and spare-count logic; a miss when full outranks fault_last.
    always_comb begin
        state_d     = state_q;
        spare_cnt_d = spare_cnt_q;
        if (start) begin
            state_d     = COLLECT;
            spare_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COLLECT: begin
                    if (alloc_s) begin
                        spare_cnt_d = spare_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (fif.fault_last) begin
                            state_d = DONE;
                        end else if (spare_cnt_q == LAST_FREE_CNT) begin
                            state_d = FULL;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else if (hit_s && fif.fault_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = COLLECT;
                    end
                end
                FULL: begin
                    if (miss_s) begin
                        state_d = FAIL;
                    end else if (hit_s && fif.fault_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, spare count and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spare_cnt_q <= {CNT_W{1'b0}};
            done_q      <= 1'b0;
            unrep_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            spare_cnt_q <= spare_cnt_d;
            done_q      <= (state_d == DONE);
            unrep_q     <= (state_d == FAIL);
        end
    end

    for (genvar g = 0; g < NUM_SPARE; g++) begin : g_lane
        spare_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (start),
            .load_i (lane_load_s[g]),
            .inc_i  (lane_inc_s[g]),
            .row_i  (fif.fault_row),
            .row_o  (lane_row_s[g]),
            .vld_o  (lane_vld_s[g]),
            .hits_o (lane_hits_s[g])
        );
        assign hit_cnt[g*HIT_W +: HIT_W] = lane_hits_s[g];
    end

    assign RRx1         = lane_row_s[0];
    assign RRx2         = lane_row_s[1];
    assign RRx3         = lane_row_s[2];
    assign RRx4         = lane_row_s[3];
    assign RLSS         = lane_vld_s;
    assign spare_cnt    = spare_cnt_q;
    assign done         = done_q;
    assign unrepairable = unrep_q;

endmodule

// File: tb/tb_row_spare_alloc.sv
// Scoreboard bench for row_spare_alloc: a behavioural model predicts every cycle's outputs.
module tb_row_spare_alloc;
    import bira_pkg::*;

    logic        clk, rst, start;
    logic [11:0] RRx1, RRx2, RRx3, RRx4;
    logic [3:0]  RLSS;
    logic [2:0]  spare_cnt;
    logic [15:0] hit_cnt;
    logic        done, unrepairable;

    int errors = 0;
    int checks = 0;

    row_spare_alloc_if fif ();

    row_spare_alloc dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fif          (fif),
        .RRx1         (RRx1),
        .RRx2         (RRx2),
        .RRx3         (RRx3),
        .RRx4         (RRx4),
        .RLSS         (RLSS),
        .spare_cnt    (spare_cnt),
        .hit_cnt      (hit_cnt),
        .done         (done),
        .unrepairable (unrepairable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] rr;
        logic [3:0]  rlss;
        logic [2:0]  cnt;
        logic [15:0] hits;
        logic        done;
        logic        unrep;
        logic        ready;
        logic [11:0] npr;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];

    // model state
    logic [11:0] m_row [4];
    logic [3:0]  m_hit [4];
    logic [3:0]  m_vld;
    int          m_cnt;
    state_t      m_st;

    task automatic model_clear(input state_t st);
        for (int i = 0; i < 4; i++) begin
            m_row[i] = 12'h000;
            m_hit[i] = 4'd0;
        end
        m_vld = 4'b0000;
        m_cnt = 0;
        m_st  = st;
    endtask

    // One clock of stimulus; the model predicts the post-edge outputs and queues them.
    task automatic step(input string nm, input logic r, input logic s, input logic v,
                        input logic [11:0] row, input logic l);
        logic match;
        int   f;
        exp_t e;
        @(negedge clk);
        rst = r; start = s;
        fif.fault_valid = v; fif.fault_row = row; fif.fault_last = l;
        match = 1'b0;
        for (int i = 0; i < 4; i++)
            if (m_vld[i] && m_row[i] == row) match = 1'b1;
        fif.comp = match;
        if (r) begin
            model_clear(IDLE);
        end else if (s) begin
            model_clear(COLLECT);
        end else if (v && (m_st == COLLECT || m_st == FULL)) begin
            if (match) begin
                for (int i = 0; i < 4; i++)
                    if (m_vld[i] && m_row[i] == row && m_hit[i] != 4'd15) m_hit[i] = m_hit[i] + 4'd1;
                if (l) m_st = DONE;
            end else if (m_st == COLLECT) begin
                f = -1;
                for (int i = 3; i >= 0; i--) if (!m_vld[i]) f = i;
                m_row[f] = row; m_vld[f] = 1'b1; m_hit[f] = 4'd1; m_cnt++;
                if (l) m_st = DONE;
                else if (m_cnt == 4) m_st = FULL;
            end else begin
                m_st = FAIL;
            end
        end
        e.rr    = {m_row[3], m_row[2], m_row[1], m_row[0]};
        e.rlss  = m_vld;
        e.cnt   = 3'(m_cnt);
        e.hits  = {m_hit[3], m_hit[2], m_hit[1], m_hit[0]};
        e.done  = (m_st == DONE);
        e.unrep = (m_st == FAIL);
        e.ready = (m_st == COLLECT) || (m_st == FULL);
        e.npr   = row;
        sb_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: pop the prediction for this edge and compare every output.
    always @(posedge clk) begin
        exp_t  e;
        string nm;
        #1;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ({RRx4, RRx3, RRx2, RRx1} !== e.rr) begin
                errors++; $display("FAIL %s rrx got=%h exp=%h", nm, {RRx4, RRx3, RRx2, RRx1}, e.rr);
            end
            checks++;
            if (RLSS !== e.rlss) begin
                errors++; $display("FAIL %s rlss got=%b exp=%b", nm, RLSS, e.rlss);
            end
            checks++;
            if (spare_cnt !== e.cnt) begin
                errors++; $display("FAIL %s spare_cnt got=%0d exp=%0d", nm, spare_cnt, e.cnt);
            end
            checks++;
            if (hit_cnt !== e.hits) begin
                errors++; $display("FAIL %s hit_cnt got=%h exp=%h", nm, hit_cnt, e.hits);
            end
            checks++;
            if (done !== e.done || unrepairable !== e.unrep || fif.fault_ready !== e.ready) begin
                errors++;
                $display("FAIL %s flags done/unrep/ready got=%b%b%b exp=%b%b%b", nm,
                         done, unrepairable, fif.fault_ready, e.done, e.unrep, e.ready);
            end
            checks++;
            if (fif.NPr !== e.npr) begin
                errors++; $display("FAIL %s npr got=%h exp=%h", nm, fif.NPr, e.npr);
            end
        end
    end

    task automatic test_reset();
        step("reset", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        step("reset_hold", 1'b1, 1'b0, 1'b1, 12'h123, 1'b0);
        step("idle_ignore", 1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
        checks++;
        if (fif.fault_ready !== 1'b0 || RLSS !== 4'b0000 || done !== 1'b0) begin
            errors++; $display("FAIL reset_state ready/rlss/done got=%b/%b/%b exp=0/0000/0",
                               fif.fault_ready, RLSS, done);
        end
    endtask

    task automatic test_basic();
        step("b_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        step("b_005", 1'b0, 1'b0, 1'b1, 12'h005, 1'b0);
        step("b_405", 1'b0, 1'b0, 1'b1, 12'h405, 1'b0);
        step("b_005hit", 1'b0, 1'b0, 1'b1, 12'h005, 1'b0);
        checks++;
        if (RRx1 !== 12'h005 || RRx2 !== 12'h405 || RLSS !== 4'b0011 || hit_cnt[7:0] !== 8'h12
            || spare_cnt !== 3'd2) begin
            errors++; $display("FAIL basic got rrx1=%h rrx2=%h rlss=%b hits=%h cnt=%0d exp 005 405 0011 12 2",
                               RRx1, RRx2, RLSS, hit_cnt[7:0], spare_cnt);
        end
    endtask

    task automatic test_fill_done();
        step("fd_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 4; i++)
            step("fd_miss", 1'b0, 1'b0, 1'b1, 12'(i), (i == 4) ? 1'b1 : 1'b0);
        checks++;
        if (RLSS !== 4'b1111 || done !== 1'b1 || unrepairable !== 1'b0 || fif.fault_ready !== 1'b0) begin
            errors++; $display("FAIL fill_done got rlss=%b done=%b unrep=%b ready=%b exp 1111 1 0 0",
                               RLSS, done, unrepairable, fif.fault_ready);
        end
        step("fd_ignored", 1'b0, 1'b0, 1'b1, 12'h0AA, 1'b0);
    endtask

    task automatic test_fail();
        step("f_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 4; i++)
            step("f_miss", 1'b0, 1'b0, 1'b1, 12'h011 + 12'(i), 1'b0);
        step("f_fifth", 1'b0, 1'b0, 1'b1, 12'h00A, 1'b0);
        checks++;
        if (unrepairable !== 1'b1 || fif.fault_ready !== 1'b0 || RRx4 !== 12'h014 || done !== 1'b0) begin
            errors++; $display("FAIL fail_state got unrep=%b ready=%b rrx4=%h done=%b exp 1 0 014 0",
                               unrepairable, fif.fault_ready, RRx4, done);
        end
        step("f_restart", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        checks++;
        if (RLSS !== 4'b0000 || RRx1 !== 12'h000 || hit_cnt !== 16'h0000 || unrepairable !== 1'b0) begin
            errors++; $display("FAIL restart_clear got rlss=%b rrx1=%h hits=%h unrep=%b exp 0000 000 0000 0",
                               RLSS, RRx1, hit_cnt, unrepairable);
        end
    endtask

    task automatic test_saturate();
        step("s_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        step("s_alloc", 1'b0, 1'b0, 1'b1, 12'h010, 1'b0);
        for (int i = 0; i < 17; i++)
            step("s_hit", 1'b0, 1'b0, 1'b1, 12'h010, 1'b0);
        checks++;
        if (hit_cnt[3:0] !== 4'd15 || RLSS !== 4'b0001 || spare_cnt !== 3'd1) begin
            errors++; $display("FAIL saturate got hits0=%0d rlss=%b cnt=%0d exp 15 0001 1",
                               hit_cnt[3:0], RLSS, spare_cnt);
        end
    endtask

    task automatic test_mid_start_rst();
        step("m_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        step("m_a", 1'b0, 1'b0, 1'b1, 12'h100, 1'b0);
        step("m_b", 1'b0, 1'b0, 1'b1, 12'h200, 1'b0);
        step("m_restart", 1'b0, 1'b1, 1'b1, 12'h300, 1'b0);
        checks++;
        if (RLSS !== 4'b0000 || spare_cnt !== 3'd0 || fif.fault_ready !== 1'b1) begin
            errors++; $display("FAIL mid_start got rlss=%b cnt=%0d ready=%b exp 0000 0 1",
                               RLSS, spare_cnt, fif.fault_ready);
        end
        step("m_a2", 1'b0, 1'b0, 1'b1, 12'h100, 1'b0);
        step("m_b2", 1'b0, 1'b0, 1'b1, 12'h200, 1'b0);
        step("m_rst", 1'b1, 1'b1, 1'b1, 12'h300, 1'b0);
        checks++;
        if (RLSS !== 4'b0000 || RRx1 !== 12'h000 || fif.fault_ready !== 1'b0 || hit_cnt !== 16'h0000) begin
            errors++; $display("FAIL mid_rst got rlss=%b rrx1=%h ready=%b hits=%h exp 0000 000 0 0000",
                               RLSS, RRx1, fif.fault_ready, hit_cnt);
        end
    endtask

    task automatic test_full_last();
        step("fl_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 4; i++)
            step("fl_miss", 1'b0, 1'b0, 1'b1, 12'(i), 1'b0);
        step("fl_hitlast", 1'b0, 1'b0, 1'b1, 12'h003, 1'b1);
        checks++;
        if (done !== 1'b1 || unrepairable !== 1'b0 || hit_cnt[11:8] !== 4'd2) begin
            errors++; $display("FAIL full_hit_last got done=%b unrep=%b hits2=%0d exp 1 0 2",
                               done, unrepairable, hit_cnt[11:8]);
        end
        step("fl_start2", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 4; i++)
            step("fl_miss2", 1'b0, 1'b0, 1'b1, 12'(i), 1'b0);
        step("fl_misslast", 1'b0, 1'b0, 1'b1, 12'h007, 1'b1);
        checks++;
        if (done !== 1'b0 || unrepairable !== 1'b1) begin
            errors++; $display("FAIL full_miss_last got done=%b unrep=%b exp 0 1", done, unrepairable);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] pool [6];
        pool[0] = 12'h005; pool[1] = 12'h105; pool[2] = 12'h205;
        pool[3] = 12'h305; pool[4] = 12'h405; pool[5] = 12'h006;
        for (int r = 0; r < 3; r++) begin
            step("bb_start", 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
            for (int i = 0; i < 25; i++)
                step("bb_rand", 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0),
                     pool[$urandom_range(0, 5)], 1'($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        fif.fault_valid = 1'b0; fif.fault_row = 12'h000;
        fif.fault_last = 1'b0; fif.comp = 1'b0;
        model_clear(IDLE);
        test_reset();
        test_basic();
        test_fill_done();
        test_fail();
        test_saturate();
        test_mid_start_rst();
        test_full_last();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
